// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 constants and the fetch FIFO entry type.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular FIFO with synchronous flush and occupancy count.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_dout,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd <= r_wr;
      r_count <= '0;
    end else begin
      r_wr <= r_wr + AW'(i_push);
      r_rd <= r_rd + AW'(i_pop);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  assign o_dout = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: credit-based instruction fetch with an in-order address queue
// and discard counting for responses made stale by a flush.
module fetch_stage import riscv_pkg::*; #(
  parameter int DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_wen,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            decode_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CW-1:0] w_fifo_cnt, w_aq_cnt, w_credits, r_discard;
  logic [XLEN-1:0] w_rsp_pc;
  fetch_entry_t w_head, w_entry;
  logic w_accept, w_keep, w_pop, w_aq_pop;
  assign w_pop = instr_valid & decode_ready;
  // a head leaving this cycle frees its credit for a same-cycle request
  assign w_credits = w_fifo_cnt + w_aq_cnt - CW'(w_pop);
  assign imem_req_valid = ~reset & ~flush & (w_credits < CW'(DEPTH));
  assign w_accept = imem_req_valid & imem_req_ready;
  assign pc_wen = ~reset & (w_accept | flush);
  assign imem_req_addr = pc;
  assign w_aq_pop = imem_rsp_valid & (w_aq_cnt != '0);
  assign w_keep = w_aq_pop & ~flush & (r_discard == '0);
  assign w_entry = '{data: imem_rsp_data, pc: w_rsp_pc};
  assign instr_valid = w_fifo_cnt != '0;
  assign instr = instr_valid ? w_head.data : NOP_INSTR;
  assign instr_pc = instr_valid ? w_head.pc : '0;
  // every request still in flight after a flush is stale
  always_ff @(posedge clk or posedge reset)
    if (reset) r_discard <= '0;
    else if (flush) r_discard <= w_aq_cnt - CW'(w_aq_pop);
    else if (w_aq_pop && r_discard != '0) r_discard <= r_discard - CW'(1);
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_aq (
    .clk, .reset,
    .i_push(w_accept), .i_din(pc), .i_pop(w_aq_pop), .i_flush(1'b0),
    .o_dout(w_rsp_pc), .o_count(w_aq_cnt)
  );
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_iq (
    .clk, .reset,
    .i_push(w_keep), .i_din(w_entry), .i_pop(w_pop), .i_flush(flush),
    .o_dout(w_head), .o_count(w_fifo_cnt)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks against a queue-based fetch model.
module tb_fetch_stage;
  import riscv_pkg::*;
  localparam int DEPTH = 2;
  logic clk = 0, reset = 1, flush = 0, imem_req_ready = 0, imem_rsp_valid = 0, decode_ready = 0;
  logic [31:0] pc = 0, imem_rsp_data = 0, target = 0;
  logic pc_wen, imem_req_valid, instr_valid;
  logic [31:0] imem_req_addr, instr, instr_pc;
  fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_wen(pc_wen), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .decode_ready(decode_ready)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] a; int due; bit live;} req_t;
  req_t mq[$];
  logic [31:0] fq[$];
  int now = 0, last_due = 0, lat_min = 1, lat_max = 1;
  int tests = 0, fails = 0;
  logic e_req, e_wen, e_valid, s_req, s_wen, s_valid;
  logic [31:0] e_instr, e_ipc, s_instr, s_ipc, s_addr, pc_seen;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic step();
    bit rsp, pop, acc;
    req_t r;
    int d;
    rsp = mq.size() > 0 && mq[0].due <= now;
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? mdata(mq[0].a) : $urandom;
    #2;
    s_req = imem_req_valid; s_wen = pc_wen; s_valid = instr_valid;
    s_instr = instr; s_ipc = instr_pc; s_addr = imem_req_addr; pc_seen = pc;
    e_valid = fq.size() > 0;
    e_ipc = e_valid ? fq[0] : 32'h0;
    e_instr = e_valid ? mdata(fq[0]) : NOP;
    pop = e_valid && decode_ready;
    e_req = !flush && (fq.size() + mq.size() - int'(pop)) < DEPTH;
    acc = e_req && imem_req_ready;
    e_wen = acc || flush;
    if (pop) void'(fq.pop_front());
    if (rsp) begin
      r = mq.pop_front();
      if (r.live && !flush) fq.push_back(r.a);
    end
    if (flush) begin
      fq.delete();
      foreach (mq[i]) mq[i].live = 0;
    end
    if (acc) begin
      d = now + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{a: pc, due: d, live: 1});
    end
    @(posedge clk); #1;
    now++;
    if (e_wen) pc = flush ? target : pc + 4;
  endtask

  task automatic do_reset();
    reset = 1; flush = 0; imem_rsp_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    mq.delete(); fq.delete(); last_due = now; pc = 0;
  endtask

  task automatic test_reset();
    imem_req_ready = 1; decode_ready = 1;
    #1;
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req_valid); end
    tests++; if (pc_wen !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b want 0", pc_wen); end
    tests++; if (instr !== NOP) begin fails++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
    tests++; if (instr_pc !== 32'h0) begin fails++; $display("FAIL reset_ipc: got %h want 0", instr_pc); end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    lat_min = 1; lat_max = 1; imem_req_ready = 1; decode_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      tests++; if (s_wen !== 1'b1) begin fails++; $display("FAIL stream_wen c%0d: got %b want 1", i, s_wen); end
      if (i >= 2 && i <= 4) begin
        tests++;
        if (s_valid !== 1'b1 || s_ipc !== 32'((i - 2) * 4) || s_instr !== mdata(32'((i - 2) * 4))) begin
          fails++; $display("FAIL stream_instr c%0d: got v=%b pc=%h d=%h want pc=%h", i, s_valid, s_ipc, s_instr, (i - 2) * 4);
        end
      end
    end
  endtask

  task automatic test_stall();
    int acc = 0;
    do_reset();
    lat_min = 1; lat_max = 1; imem_req_ready = 1; decode_ready = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_req && imem_req_ready) acc++;
    end
    tests++; if (acc != 2) begin fails++; $display("FAIL stall_count: got %0d want 2", acc); end
    tests++; if (s_req !== 1'b0 || s_wen !== 1'b0) begin fails++; $display("FAIL stall_hold: got req=%b wen=%b want 0 0", s_req, s_wen); end
    decode_ready = 1;
    step();
    tests++; if (s_wen !== 1'b1 || s_ipc !== 32'h0) begin fails++; $display("FAIL stall_release: got wen=%b pc=%h want 1 0", s_wen, s_ipc); end
  endtask

  task automatic test_flush();
    int stale = 0;
    logic [31:0] first = 32'hFFFF_FFFF;
    do_reset();
    lat_min = 3; lat_max = 3; imem_req_ready = 1; decode_ready = 0;
    repeat (2) step();
    flush = 1; target = 32'h100;
    step();
    tests++; if (s_wen !== 1'b1 || s_req !== 1'b0) begin fails++; $display("FAIL flush_strobe: got wen=%b req=%b want 1 0", s_wen, s_req); end
    flush = 0; decode_ready = 1; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_valid && (s_ipc == 32'h0 || s_ipc == 32'h4)) stale++;
      if (s_valid && first == 32'hFFFF_FFFF) first = s_ipc;
    end
    tests++; if (stale != 0) begin fails++; $display("FAIL flush_stale: got %0d want 0", stale); end
    tests++; if (first !== 32'h100) begin fails++; $display("FAIL flush_target: got %h want 00000100", first); end
  endtask

  task automatic test_flush_rsp();
    int seen8 = 0;
    logic [31:0] first = 32'hFFFF_FFFF;
    do_reset();
    lat_min = 1; lat_max = 1; imem_req_ready = 1; decode_ready = 1;
    repeat (3) step();
    flush = 1; target = 32'h200;
    step();
    tests++; if (s_wen !== 1'b1) begin fails++; $display("FAIL flushrsp_wen: got %b want 1", s_wen); end
    flush = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_valid && s_ipc == 32'h8) seen8++;
      if (s_valid && first == 32'hFFFF_FFFF) first = s_ipc;
    end
    tests++; if (seen8 != 0) begin fails++; $display("FAIL flushrsp_drop: got %0d want 0", seen8); end
    tests++; if (first !== 32'h200) begin fails++; $display("FAIL flushrsp_target: got %h want 00000200", first); end
  endtask

  task automatic test_ready_low();
    logic [31:0] first = 32'hFFFF_FFFF;
    do_reset();
    lat_min = 1; lat_max = 2; imem_req_ready = 0; decode_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (s_addr !== pc_seen || s_wen !== 1'b0 || s_req !== 1'b1) begin
        fails++; $display("FAIL ready_low c%0d: got addr=%h wen=%b req=%b want addr=%h wen=0 req=1", i, s_addr, s_wen, s_req, pc_seen);
      end
    end
    imem_req_ready = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_valid && first == 32'hFFFF_FFFF) first = s_ipc;
    end
    tests++; if (first !== 32'h0) begin fails++; $display("FAIL ready_low_first: got %h want 0", first); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    logic [31:0] first = 32'hFFFF_FFFF;
    do_reset();
    lat_min = 3; lat_max = 3; imem_req_ready = 1; decode_ready = 0;
    step();
    imem_req_ready = 0;
    #2 reset = 1;
    #1;
    tests++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_wen !== 1'b0 || instr !== NOP || instr_pc !== 32'h0) begin
      fails++; $display("FAIL reset_mid: got v=%b req=%b wen=%b instr=%h pc=%h", instr_valid, imem_req_valid, pc_wen, instr, instr_pc);
    end
    imem_rsp_valid = 1; imem_rsp_data = mdata(32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    mq.delete(); fq.delete(); last_due = now; pc = 32'h40;
    lat_min = 1; lat_max = 1; imem_req_ready = 1; decode_ready = 1;
    step();
    tests++; if (s_req !== 1'b1) begin fails++; $display("FAIL reset_first_req: got %b want 1", s_req); end
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_valid && s_ipc == 32'h0) bad++;
      if (s_valid && first == 32'hFFFF_FFFF) first = s_ipc;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL reset_late_rsp: got %0d want 0", bad); end
    tests++; if (first !== 32'h40) begin fails++; $display("FAIL reset_restart: got %h want 00000040", first); end
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = $urandom_range(3, 0) != 0;
      decode_ready = $urandom_range(9, 0) < 7;
      flush = $urandom_range(19, 0) == 0;
      target = $urandom & 32'hFFFF_FFFC;
      step();
      tests++;
      if (s_req !== e_req || s_wen !== e_wen || s_valid !== e_valid || s_instr !== e_instr || s_ipc !== e_ipc || s_addr !== pc_seen) begin
        fails++;
        if (shown++ < 20)
          $display("FAIL random c%0d: got req=%b wen=%b v=%b instr=%h pc=%h addr=%h want req=%b wen=%b v=%b instr=%h pc=%h addr=%h",
                   i, s_req, s_wen, s_valid, s_instr, s_ipc, s_addr, e_req, e_wen, e_valid, e_instr, e_ipc, pc_seen);
      end
    end
    flush = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_rsp();
    test_ready_low();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DEPTH, default 2: max instructions buffered plus in flight; power of two, 2..8.
REQ-002 Parameter NOP_INSTR, default 32'h00000013: value driven on instr when instr_valid=0.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc  input  32  current fetch address from the program counter.
REQ-006 pc_wen  output  1  advance/load strobe to the program counter.
REQ-007 flush  input  1  branch taken this cycle; the program counter loads its target when pc_wen=1.
REQ-008 imem_req_valid  output  1  read request to instruction memory.
REQ-009 imem_req_ready  input  1  memory accepts the request.
REQ-010 imem_req_addr  output  32  request address; equals pc.
REQ-011 imem_rsp_valid  input  1  read data valid; in order, at least 1 cycle after acceptance.
REQ-012 imem_rsp_data  input  32  instruction word.
REQ-013 instr_valid  output  1  instruction available to decode.
REQ-014 instr  output  32  instruction word at FIFO head.
REQ-015 instr_pc  output  32  address of instr.
REQ-016 decode_ready  input  1  decode consumes head when instr_valid=1.

Function
REQ-017 Credit count = FIFO occupancy + outstanding requests; it shall never exceed DEPTH.
REQ-018 imem_req_valid shall be 1 iff credit count < DEPTH, flush=0 and not in reset.
REQ-019 Request acceptance = imem_req_valid & imem_req_ready; pc for each accepted request shall be pushed into an in-order address queue.
REQ-020 pc_wen shall be combinational: acceptance OR flush.
REQ-021 A response with discard count 0 shall write {data, queued pc} into the FIFO in the same edge; instr_valid rises the next cycle.
REQ-022 Head pops when instr_valid & decode_ready; push and pop in the same cycle shall leave occupancy unchanged.
REQ-023 Credits shall be released when an entry pops or a discarded response arrives.
REQ-024 On flush: FIFO emptied; discard count loaded with outstanding count (excluding a response arriving that same cycle, which is itself dropped); no request issued that cycle.
REQ-025 While discard count > 0, each response shall be dropped and decrement it; the address queue shall pop regardless.
REQ-026 Flush while discard count > 0 shall add the new outstanding requests to the remaining count.
REQ-027 instr shall equal NOP_INSTR and instr_pc 0 while instr_valid=0.
REQ-028 Throughput: 1 instruction/cycle sustained with 1-cycle memory latency and DEPTH>=2.

Reset
REQ-029 Reset shall asynchronously clear FIFO, address queue, outstanding and discard counters; instr_valid=0, imem_req_valid=0, pc_wen=0, instr=NOP_INSTR, instr_pc=0.
REQ-030 Reset mid-operation shall abandon all in-flight requests; responses arriving during reset are ignored.
REQ-031 First request shall issue the first cycle after reset deasserts.

Structure
REQ-032 XLEN=32 and NOP constant shall live in the shared riscv_pkg package.
REQ-033 One sub-module fetch_fifo (parameterized width/depth, push/pop/flush, count) shall implement both the instruction FIFO and the address queue.

Verification
REQ-034 Reset, pc=0x0, ready=1, 1-cycle latency, decode_ready=1 -> instrs at 0x0,0x4,0x8 on consecutive cycles, pc_wen=1 every cycle.
REQ-035 decode_ready=0 with DEPTH=2 -> exactly 2 requests issued, then imem_req_valid=0, pc_wen=0 until a pop.
REQ-036 Flush with 2 requests outstanding, target 0x100 -> both stale responses dropped; next instr_pc=0x100.
REQ-037 Flush same cycle as response at 0x8 -> 0x8 never presented; pc_wen=1 that cycle.
REQ-038 imem_req_ready=0 for 5 cycles -> imem_req_addr held at pc, pc_wen=0, no queue push.
REQ-039 Reset asserted with 1 outstanding -> outputs at REQ-029 values immediately; late response ignored.
